// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the layer tile scheduler.
package tile_sched_pkg;

  localparam int unsigned CMD_W     = 16;
  localparam int unsigned ROW_ACC_W = 9;

  localparam logic [1:0] LT_PW  = 2'd0;
  localparam logic [1:0] LT_DW  = 2'd1;
  localparam logic [1:0] LT_STD = 2'd2;
  localparam logic [1:0] LT_LIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [CMD_W-1:0] row_start;
    logic [CMD_W-1:0] rows;
    logic [CMD_W-1:0] out_row_start;
    logic [CMD_W-1:0] d_start;
    logic [CMD_W-1:0] d_len;
    logic [CMD_W-1:0] k_start;
    logic [CMD_W-1:0] k_len;
    logic             first_d;
    logic             last_d;
  } tile_cmd_t;

endpackage

// File: rtl/tile_loop_cnt.sv
// One tile loop level: index, start accumulator, clamped length and wrap carry.
module tile_loop_cnt #(
  parameter int unsigned IDX_W = 7,
  parameter int unsigned ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  input  logic [IDX_W-1:0] i_num,
  input  logic [ACC_W-1:0] i_inc,
  input  logic [ACC_W-1:0] i_tile,
  input  logic [ACC_W-1:0] i_total,
  output logic [ACC_W-1:0] o_start,
  output logic [ACC_W-1:0] o_len,
  output logic             o_first,
  output logic             o_last,
  output logic             o_carry_c
);

  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_start;
  logic [ACC_W-1:0] r_len;
  logic             r_first;
  logic             r_last;
  logic [ACC_W-1:0] w_next_start;

  // Tile length clipped at the end of the dimension; compare one bit wider.
  function automatic logic [ACC_W-1:0] f_len(input logic [ACC_W-1:0] s,
                                             input logic [ACC_W-1:0] t,
                                             input logic [ACC_W-1:0] tot);
    logic [ACC_W:0] v_end;
    v_end = {1'b0, s} + {1'b0, t};
    f_len = (v_end <= {1'b0, tot}) ? t : (tot - s);
  endfunction

  assign w_next_start = r_start + i_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_clear || (i_step && r_last)) begin
      r_idx   <= '0;
      r_start <= '0;
      r_len   <= f_len('0, i_tile, i_total);
      r_first <= 1'b1;
      r_last  <= (i_num == IDX_W'(1));
    end else if (i_step) begin
      r_idx   <= r_idx + IDX_W'(1);
      r_start <= w_next_start;
      r_len   <= f_len(w_next_start, i_tile, i_total);
      r_first <= 1'b0;
      r_last  <= ((r_idx + IDX_W'(1)) == (i_num - IDX_W'(1)));
    end
  end

  assign o_start   = r_start;
  assign o_len     = r_len;
  assign o_first   = r_first;
  assign o_last    = r_last;
  assign o_carry_c = i_step && r_last;

endmodule

// File: rtl/tile_scheduler.sv
// Walks K (outer), row (middle) and D (inner) tiles of one layer and issues
// one tile command per step, waiting for each tile's completion.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 7,
  parameter int unsigned CH_W  = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       layer_type_i,
  input  logic [1:0]       stride_i,
  input  logic [CNT_W-1:0] padded_R_i,
  input  logic [CH_W-1:0]  in_D_i,
  input  logic [CH_W-1:0]  out_K_i,
  input  logic [CNT_W-1:0] tile_R_i,
  input  logic [CNT_W-1:0] out_tile_R_i,
  input  logic [CNT_W-1:0] tile_D_i,
  input  logic [CNT_W-1:0] tile_K_i,
  input  logic [CNT_W-1:0] num_tiles_R_i,
  input  logic [CNT_W-1:0] num_tiles_D_i,
  input  logic [CNT_W-1:0] num_tiles_K_i,
  output logic             cmd_valid_o,
  input  logic             cmd_ready_i,
  output logic [CNT_W-1:0] cmd_row_start_o,
  output logic [CNT_W-1:0] cmd_rows_o,
  output logic [CNT_W-1:0] cmd_out_row_start_o,
  output logic [CH_W-1:0]  cmd_d_start_o,
  output logic [CH_W-1:0]  cmd_d_len_o,
  output logic [CH_W-1:0]  cmd_k_start_o,
  output logic [CH_W-1:0]  cmd_k_len_o,
  output logic             cmd_first_d_o,
  output logic             cmd_last_d_o,
  input  logic             tile_done_i,
  output logic             busy_o,
  output logic             layer_done_o
);

  sched_state_e r_state, w_next;
  logic r_valid, r_busy, r_done;
  logic w_clear, w_step;

  logic [1:0]       r_layer_type, r_stride;
  logic [CNT_W-1:0] r_padded_r, r_tile_r, r_out_tile_r, r_tile_d, r_tile_k;
  logic [CNT_W-1:0] r_num_r, r_num_d, r_num_k;
  logic [CH_W-1:0]  r_in_d, r_out_k;
  logic [CNT_W-1:0] r_out_row;

  // In IDLE the loops are cleared from the live inputs being latched.
  logic             w_sel_in;
  logic [1:0]       w_layer_type, w_stride;
  logic [CNT_W-1:0] w_padded_r, w_tile_r, w_out_tile_r, w_tile_d, w_tile_k;
  logic [CNT_W-1:0] w_num_r, w_num_d, w_num_k, w_num_d_eff;
  logic [CH_W-1:0]  w_in_d, w_out_k;
  logic             w_any_zero;

  assign w_sel_in     = (r_state == IDLE);
  assign w_layer_type = w_sel_in ? layer_type_i  : r_layer_type;
  assign w_stride     = w_sel_in ? stride_i      : r_stride;
  assign w_padded_r   = w_sel_in ? padded_R_i    : r_padded_r;
  assign w_tile_r     = w_sel_in ? tile_R_i      : r_tile_r;
  assign w_out_tile_r = w_sel_in ? out_tile_R_i  : r_out_tile_r;
  assign w_tile_d     = w_sel_in ? tile_D_i      : r_tile_d;
  assign w_tile_k     = w_sel_in ? tile_K_i      : r_tile_k;
  assign w_num_r      = w_sel_in ? num_tiles_R_i : r_num_r;
  assign w_num_d      = w_sel_in ? num_tiles_D_i : r_num_d;
  assign w_num_k      = w_sel_in ? num_tiles_K_i : r_num_k;
  assign w_in_d       = w_sel_in ? in_D_i        : r_in_d;
  assign w_out_k      = w_sel_in ? out_K_i       : r_out_k;
  assign w_num_d_eff  = (w_layer_type == LT_DW) ? CNT_W'(1) : w_num_d;
  assign w_any_zero   = (num_tiles_R_i == '0) || (num_tiles_D_i == '0) ||
                        (num_tiles_K_i == '0);

  // Row step out_tile_R*stride built from shift/add.
  logic [ROW_ACC_W-1:0] w_otr_x, w_row_inc;
  assign w_otr_x = ROW_ACC_W'(w_out_tile_r);
  always_comb begin
    w_row_inc = '0;
    unique case (w_stride)
      2'd1:    w_row_inc = w_otr_x;
      2'd2:    w_row_inc = w_otr_x << 1;
      2'd3:    w_row_inc = w_otr_x + (w_otr_x << 1);
      default: w_row_inc = '0;
    endcase
  end

  logic [ROW_ACC_W-1:0] w_r_start, w_r_len;
  logic [CH_W-1:0]      w_d_start, w_d_len, w_k_start, w_k_len;
  logic w_d_first, w_d_last, w_d_carry;
  logic w_r_first, w_r_last, w_r_carry;
  logic w_k_first, w_k_last, w_k_carry;
  logic w_unused;
  assign w_unused = w_r_first ^ w_k_first ^ w_k_carry;

  tile_loop_cnt #(.IDX_W(CNT_W), .ACC_W(CH_W)) u_loop_d (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_step(w_step),
    .i_num(w_num_d_eff), .i_inc(CH_W'(w_tile_d)), .i_tile(CH_W'(w_tile_d)),
    .i_total(w_in_d), .o_start(w_d_start), .o_len(w_d_len),
    .o_first(w_d_first), .o_last(w_d_last), .o_carry_c(w_d_carry)
  );

  tile_loop_cnt #(.IDX_W(CNT_W), .ACC_W(ROW_ACC_W)) u_loop_r (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_step(w_d_carry),
    .i_num(w_num_r), .i_inc(w_row_inc), .i_tile(ROW_ACC_W'(w_tile_r)),
    .i_total(ROW_ACC_W'(w_padded_r)), .o_start(w_r_start), .o_len(w_r_len),
    .o_first(w_r_first), .o_last(w_r_last), .o_carry_c(w_r_carry)
  );

  tile_loop_cnt #(.IDX_W(CNT_W), .ACC_W(CH_W)) u_loop_k (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clear), .i_step(w_r_carry),
    .i_num(w_num_k), .i_inc(CH_W'(w_tile_k)), .i_tile(CH_W'(w_tile_k)),
    .i_total(w_out_k), .o_start(w_k_start), .o_len(w_k_len),
    .o_first(w_k_first), .o_last(w_k_last), .o_carry_c(w_k_carry)
  );

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_step  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_clear = 1'b1;
          w_next  = w_any_zero ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (abort_i)          w_next = IDLE;
        else if (cmd_ready_i) w_next = WAIT;
      end
      WAIT: begin
        if (abort_i) begin
          w_next = IDLE;
        end else if (tile_done_i) begin
          w_step = 1'b1;
          w_next = (w_d_last && w_r_last && w_k_last) ? DONE : ISSUE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == ISSUE);
      r_busy  <= (w_next != IDLE);
      r_done  <= (w_next == DONE);
    end
  end

  // Layer parameter latch and output-row accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer_type <= '0; r_stride  <= '0; r_padded_r <= '0;
      r_tile_r     <= '0; r_out_tile_r <= '0; r_tile_d <= '0;
      r_tile_k     <= '0; r_num_r   <= '0; r_num_d    <= '0;
      r_num_k      <= '0; r_in_d    <= '0; r_out_k    <= '0;
      r_out_row    <= '0;
    end else begin
      if (w_clear) begin
        r_layer_type <= layer_type_i;  r_stride     <= stride_i;
        r_padded_r   <= padded_R_i;    r_tile_r     <= tile_R_i;
        r_out_tile_r <= out_tile_R_i;  r_tile_d     <= tile_D_i;
        r_tile_k     <= tile_K_i;      r_num_r      <= num_tiles_R_i;
        r_num_d      <= num_tiles_D_i; r_num_k      <= num_tiles_K_i;
        r_in_d       <= in_D_i;        r_out_k      <= out_K_i;
        r_out_row    <= '0;
      end else if (w_d_carry) begin
        r_out_row <= w_r_last ? '0 : (r_out_row + r_out_tile_r);
      end
    end
  end

  tile_cmd_t w_cmd;
  always_comb begin
    w_cmd               = '0;
    w_cmd.row_start     = CMD_W'(w_r_start);
    w_cmd.rows          = CMD_W'(w_r_len);
    w_cmd.out_row_start = CMD_W'(r_out_row);
    w_cmd.k_start       = CMD_W'(w_k_start);
    w_cmd.k_len         = CMD_W'(w_k_len);
    w_cmd.d_start       = CMD_W'(w_d_start);
    w_cmd.d_len         = CMD_W'(w_d_len);
    w_cmd.first_d       = w_d_first;
    w_cmd.last_d        = w_d_last;
    // Depthwise: each output channel sees only its own input channel.
    if (r_layer_type == LT_DW) begin
      w_cmd.d_start = CMD_W'(w_k_start);
      w_cmd.d_len   = CMD_W'(w_k_len);
      w_cmd.first_d = 1'b1;
      w_cmd.last_d  = 1'b1;
    end
  end

  assign cmd_valid_o         = r_valid;
  assign busy_o              = r_busy;
  assign layer_done_o        = r_done;
  assign cmd_row_start_o     = CNT_W'(w_cmd.row_start);
  assign cmd_rows_o          = CNT_W'(w_cmd.rows);
  assign cmd_out_row_start_o = CNT_W'(w_cmd.out_row_start);
  assign cmd_d_start_o       = CH_W'(w_cmd.d_start);
  assign cmd_d_len_o         = CH_W'(w_cmd.d_len);
  assign cmd_k_start_o       = CH_W'(w_cmd.k_start);
  assign cmd_k_len_o         = CH_W'(w_cmd.k_len);
  assign cmd_first_d_o       = w_cmd.first_d;
  assign cmd_last_d_o        = w_cmd.last_d;

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed self-checking bench for tile_scheduler.
module tb_tile_scheduler;
  import tile_sched_pkg::*;

  localparam int unsigned CNT_W = 7;
  localparam int unsigned CH_W  = 11;

  logic             clk, rst_n, start_i, abort_i, cmd_ready_i, tile_done_i;
  logic [1:0]       layer_type_i, stride_i;
  logic [CNT_W-1:0] padded_R_i, tile_R_i, out_tile_R_i, tile_D_i, tile_K_i;
  logic [CNT_W-1:0] num_tiles_R_i, num_tiles_D_i, num_tiles_K_i;
  logic [CH_W-1:0]  in_D_i, out_K_i;
  logic             cmd_valid_o, cmd_first_d_o, cmd_last_d_o, busy_o, layer_done_o;
  logic [CNT_W-1:0] cmd_row_start_o, cmd_rows_o, cmd_out_row_start_o;
  logic [CH_W-1:0]  cmd_d_start_o, cmd_d_len_o, cmd_k_start_o, cmd_k_len_o;

  tile_scheduler #(.CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .layer_type_i(layer_type_i), .stride_i(stride_i), .padded_R_i(padded_R_i),
    .in_D_i(in_D_i), .out_K_i(out_K_i), .tile_R_i(tile_R_i),
    .out_tile_R_i(out_tile_R_i), .tile_D_i(tile_D_i), .tile_K_i(tile_K_i),
    .num_tiles_R_i(num_tiles_R_i), .num_tiles_D_i(num_tiles_D_i),
    .num_tiles_K_i(num_tiles_K_i), .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i), .cmd_row_start_o(cmd_row_start_o),
    .cmd_rows_o(cmd_rows_o), .cmd_out_row_start_o(cmd_out_row_start_o),
    .cmd_d_start_o(cmd_d_start_o), .cmd_d_len_o(cmd_d_len_o),
    .cmd_k_start_o(cmd_k_start_o), .cmd_k_len_o(cmd_k_len_o),
    .cmd_first_d_o(cmd_first_d_o), .cmd_last_d_o(cmd_last_d_o),
    .tile_done_i(tile_done_i), .busy_o(busy_o), .layer_done_o(layer_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected command sequence for the pointwise layer (r,d order).
  int s1_rs   [6] = '{0, 0, 4, 4, 8, 8};
  int s1_rows [6] = '{4, 4, 4, 4, 2, 2};
  int s1_ds   [6] = '{0, 32, 0, 32, 0, 32};
  int s1_dl   [6] = '{32, 8, 32, 8, 32, 8};
  int s1_fd   [6] = '{1, 0, 1, 0, 1, 0};
  int s1_ld   [6] = '{0, 1, 0, 1, 0, 1};
  int s2_ks   [3] = '{0, 8, 16};
  int s2_kl   [3] = '{8, 8, 4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] lt, input logic [1:0] st, input int pr,
                      input int ind, input int outk, input int tr, input int otr,
                      input int td, input int tk, input int nr, input int nd,
                      input int nk);
    layer_type_i  = lt;           stride_i      = st;
    padded_R_i    = CNT_W'(pr);   in_D_i        = CH_W'(ind);
    out_K_i       = CH_W'(outk);  tile_R_i      = CNT_W'(tr);
    out_tile_R_i  = CNT_W'(otr);  tile_D_i      = CNT_W'(td);
    tile_K_i      = CNT_W'(tk);   num_tiles_R_i = CNT_W'(nr);
    num_tiles_D_i = CNT_W'(nd);   num_tiles_K_i = CNT_W'(nk);
  endtask

  task automatic expect_cmd(input string tag, input int rs, input int rows,
                            input int ors, input int ds, input int dl, input int ks,
                            input int kl, input int fd, input int ld);
    chk({tag, "_valid"},   32'(cmd_valid_o), 1);
    chk({tag, "_row_st"},  32'(cmd_row_start_o), rs);
    chk({tag, "_rows"},    32'(cmd_rows_o), rows);
    chk({tag, "_orow_st"}, 32'(cmd_out_row_start_o), ors);
    chk({tag, "_d_st"},    32'(cmd_d_start_o), ds);
    chk({tag, "_d_len"},   32'(cmd_d_len_o), dl);
    chk({tag, "_k_st"},    32'(cmd_k_start_o), ks);
    chk({tag, "_k_len"},   32'(cmd_k_len_o), kl);
    chk({tag, "_first"},   32'(cmd_first_d_o), fd);
    chk({tag, "_last"},    32'(cmd_last_d_o), ld);
  endtask

  // Handshake the current command, then report it finished.
  task automatic serve(input string tag);
    cmd_ready_i = 1'b1; tick; cmd_ready_i = 1'b0;
    chk({tag, "_wait_novalid"}, 32'(cmd_valid_o), 0);
    tile_done_i = 1'b1; tick; tile_done_i = 1'b0;
  endtask

  task automatic run_scn1(input string tag);
    load(LT_PW, 2'd1, 10, 40, 32, 4, 4, 32, 32, 3, 2, 1);
    start_i = 1'b1; tick; start_i = 1'b0;
    chk({tag, "_busy_t1"}, 32'(busy_o), 1);
    for (int i = 0; i < 6; i++) begin
      expect_cmd($sformatf("%s_cmd%0d", tag, i), s1_rs[i], s1_rows[i], s1_rs[i],
                 s1_ds[i], s1_dl[i], 0, 32, s1_fd[i], s1_ld[i]);
      serve($sformatf("%s_cmd%0d", tag, i));
      if (i < 5) chk($sformatf("%s_nodone%0d", tag, i), 32'(layer_done_o), 0);
    end
    chk({tag, "_done"}, 32'(layer_done_o), 1);
    chk({tag, "_done_novalid"}, 32'(cmd_valid_o), 0);
    chk({tag, "_done_busy"}, 32'(busy_o), 1);
    tick;
    chk({tag, "_done_pulse"}, 32'(layer_done_o), 0);
    chk({tag, "_idle_busy"}, 32'(busy_o), 0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; cmd_ready_i = 1'b0; tile_done_i = 1'b0;
    load(LT_PW, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick; tick;
    chk("rst_valid", 32'(cmd_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(layer_done_o), 0);
    chk("rst_rows", 32'(cmd_rows_o), 0);
    rst_n = 1'b1;
    tick;

    run_scn1("pw");

    // Depthwise: D loop collapses onto the K window.
    load(LT_DW, 2'd1, 10, 20, 20, 4, 4, 8, 8, 1, 2, 3);
    start_i = 1'b1; tick; start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_cmd($sformatf("dw_cmd%0d", i), 0, 4, 0, s2_ks[i], s2_kl[i],
                 s2_ks[i], s2_kl[i], 1, 1);
      serve($sformatf("dw_cmd%0d", i));
    end
    chk("dw_done", 32'(layer_done_o), 1);
    tick;

    // Backpressure, handshake with coincident tile_done, busy start, abort.
    load(LT_PW, 2'd1, 10, 40, 32, 4, 4, 32, 32, 3, 2, 1);
    start_i = 1'b1; tick; start_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), 32'(cmd_valid_o), 1);
      chk($sformatf("bp_rs%0d", c), 32'(cmd_row_start_o), 0);
      chk($sformatf("bp_rows%0d", c), 32'(cmd_rows_o), 4);
      chk($sformatf("bp_dlen%0d", c), 32'(cmd_d_len_o), 32);
      tick;
    end
    cmd_ready_i = 1'b1; tile_done_i = 1'b1; tick;
    cmd_ready_i = 1'b0; tile_done_i = 1'b0;
    chk("bp_hs_wait", 32'(cmd_valid_o), 0);
    tick;
    chk("bp_done_ignored", 32'(cmd_valid_o), 0);
    tile_done_i = 1'b1; tick; tile_done_i = 1'b0;
    expect_cmd("bp_cmd1", 0, 4, 0, 32, 8, 0, 32, 0, 1);
    cmd_ready_i = 1'b1; tick; cmd_ready_i = 1'b0;
    load(LT_STD, 2'd2, 5, 100, 100, 5, 2, 16, 16, 1, 1, 1);
    start_i = 1'b1; tick; start_i = 1'b0;
    chk("busy_start_busy", 32'(busy_o), 1);
    chk("busy_start_novalid", 32'(cmd_valid_o), 0);
    tile_done_i = 1'b1; tick; tile_done_i = 1'b0;
    expect_cmd("bp_cmd2", 4, 4, 4, 0, 32, 0, 32, 1, 0);
    cmd_ready_i = 1'b1; tick; cmd_ready_i = 1'b0;
    abort_i = 1'b1; tile_done_i = 1'b1; tick;
    abort_i = 1'b0; tile_done_i = 1'b0;
    chk("abort_valid", 32'(cmd_valid_o), 0);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_done", 32'(layer_done_o), 0);
    tick;
    chk("abort_done2", 32'(layer_done_o), 0);
    chk("abort_valid2", 32'(cmd_valid_o), 0);

    // Zero trip count finishes immediately.
    load(LT_LIN, 2'd1, 10, 40, 32, 4, 4, 32, 32, 3, 2, 0);
    start_i = 1'b1; tick; start_i = 1'b0;
    chk("zero_done", 32'(layer_done_o), 1);
    chk("zero_novalid", 32'(cmd_valid_o), 0);
    chk("zero_busy", 32'(busy_o), 1);
    tick;
    chk("zero_done_pulse", 32'(layer_done_o), 0);
    chk("zero_novalid2", 32'(cmd_valid_o), 0);
    chk("zero_idle", 32'(busy_o), 0);

    // Asynchronous reset while a command is pending.
    load(LT_PW, 2'd1, 10, 40, 32, 4, 4, 32, 32, 3, 2, 1);
    start_i = 1'b1; tick; start_i = 1'b0;
    chk("mrst_pre_valid", 32'(cmd_valid_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(cmd_valid_o), 0);
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_done", 32'(layer_done_o), 0);
    chk("mrst_rows", 32'(cmd_rows_o), 0);
    chk("mrst_dlen", 32'(cmd_d_len_o), 0);
    #1 rst_n = 1'b1;
    tick;
    run_scn1("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
